// File: rtl/aes_sig_pkg.sv
// Shared constants, FSM state type and MISR step function for the AES
// signature collector.
package aes_sig_pkg;

    localparam int SIG_W      = 128;
    localparam int SIG_BITS_W = 7;
    localparam logic [SIG_W-1:0] MISR_POLY = 128'h87;

    typedef enum logic {
        ACCUM = 1'b0,
        SHIFT = 1'b1
    } sig_state_e;

    // One MISR step: multiply by x in GF(2^128) and absorb the new result.
    function automatic logic [SIG_W-1:0] misr_fold(input logic [SIG_W-1:0] m,
                                                   input logic [SIG_W-1:0] d);
        return {m[SIG_W-2:0], 1'b0} ^ (m[SIG_W-1] ? MISR_POLY : {SIG_W{1'b0}}) ^ d;
    endfunction

endpackage

// File: rtl/launch_delay.sv
// LATENCY-deep 1-bit shift register with synchronous clear; its output is
// aligned with the cycle in which the core pipeline presents the result.
module launch_delay #(
    parameter int LATENCY = 21
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [LATENCY-1:0] sr_q;
    logic [LATENCY-1:0] sr_d;

    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = din;
        for (int i = 1; i < LATENCY; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[LATENCY-1];

endmodule

// File: rtl/aes_sig_collector.sv
// Folds valid AES core results into a 128-bit MISR and serializes the
// signature MSB-first on request.
module aes_sig_collector
    import aes_sig_pkg::*;
#(
    parameter int LATENCY = 21,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             launch,
    input  logic [127:0]     aes_out,
    input  logic             dump,
    output logic             sig_out,
    output logic             sig_valid,
    output logic             busy,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             overrun
);

    logic vld;

    launch_delay #(.LATENCY(LATENCY)) u_launch_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (launch),
        .dout (vld)
    );

    sig_state_e            state_q, state_d;
    logic [SIG_W-1:0]      misr_q, misr_d;
    logic [SIG_W-1:0]      shreg_q, shreg_d;
    logic [SIG_BITS_W-1:0] bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovr_q, ovr_d;
    logic                  busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        misr_d   = misr_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        cnt_d    = cnt_q;
        ovr_d    = ovr_q;
        busy_d   = busy_q;
        case (state_q)
            ACCUM: begin
                if (vld) begin
                    misr_d = misr_fold(misr_q, aes_out);
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                // Snapshot takes the post-fold value so a same-cycle result is kept.
                if (dump) begin
                    shreg_d  = misr_d;
                    misr_d   = '0;
                    cnt_d    = '0;
                    ovr_d    = 1'b0;
                    bitcnt_d = '0;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d  = {shreg_q[SIG_W-2:0], 1'b0};
                bitcnt_d = bitcnt_q + {{(SIG_BITS_W-1){1'b0}}, 1'b1};
                if (vld) begin
                    ovr_d = 1'b1;
                end
                if (bitcnt_q == {SIG_BITS_W{1'b1}}) begin
                    busy_d  = 1'b0;
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACCUM;
            misr_q   <= '0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            cnt_q    <= '0;
            ovr_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            misr_q   <= misr_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            cnt_q    <= cnt_d;
            ovr_q    <= ovr_d;
            busy_q   <= busy_d;
        end
    end

    // The shift register drains to zero, so its MSB is already 0 outside readout.
    assign sig_out    = shreg_q[SIG_W-1];
    assign sig_valid  = busy_q;
    assign busy       = busy_q;
    assign sample_cnt = cnt_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_aes_sig_collector.sv
// Directed bench: expected serial bits are queued at each dump and compared
// as the collector shifts them out.
module tb_aes_sig_collector;

    localparam int LAT = 21;

    logic         clk;
    logic         rst;
    logic         launch;
    logic [127:0] aes_out;
    logic         dump;
    logic         sig_out;
    logic         sig_valid;
    logic         busy;
    logic [15:0]  sample_cnt;
    logic         overrun;

    aes_sig_collector #(.LATENCY(LAT), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .launch     (launch),
        .aes_out    (aes_out),
        .dump       (dump),
        .sig_out    (sig_out),
        .sig_valid  (sig_valid),
        .busy       (busy),
        .sample_cnt (sample_cnt),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic         sb[$];
    logic [127:0] exp_misr = '0;
    logic [15:0]  exp_cnt  = '0;
    logic [127:0] bd[4];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] model_fold(input logic [127:0] m, input logic [127:0] d);
        logic [127:0] r;
        r = {m[126:0], 1'b0} ^ d;
        if (m[127]) r = r ^ 128'h87;
        return r;
    endfunction

    // Serial checker: one expected bit is consumed per valid output cycle.
    always @(negedge clk) begin
        if (sig_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 128'(sig_out), 128'hx);
            end else begin
                chk("sig_bit", 128'(sig_out), 128'(sb.pop_front()));
            end
        end
    end

    // n back-to-back launches; results bd[0..n-1] presented LAT cycles later.
    task automatic burst(input int n);
        launch = 1'b1;
        repeat (n) tick();
        launch = 1'b0;
        repeat (LAT - n) tick();
        for (int i = 0; i < n; i++) begin
            aes_out = bd[i];
            chk("cnt_before_fold", 128'(sample_cnt), 128'(exp_cnt));
            exp_misr = model_fold(exp_misr, bd[i]);
            exp_cnt  = exp_cnt + 16'd1;
            tick();
        end
        aes_out = '0;
        chk("cnt_after_folds", 128'(sample_cnt), 128'(exp_cnt));
    endtask

    task automatic start_dump();
        dump = 1'b1;
        for (int i = 127; i >= 0; i--) sb.push_back(exp_misr[i]);
        exp_misr = '0;
        exp_cnt  = '0;
        tick();
        dump = 1'b0;
        chk("busy_d1", 128'(busy), 128'd1);
        chk("valid_d1", 128'(sig_valid), 128'd1);
        chk("ovr_d1", 128'(overrun), 128'd0);
        chk("cnt_d1", 128'(sample_cnt), 128'd0);
    endtask

    task automatic do_dump();
        start_dump();
        repeat (127) tick();
        chk("busy_d128", 128'(busy), 128'd1);
        tick();
        chk("busy_d129", 128'(busy), 128'd0);
        chk("valid_d129", 128'(sig_valid), 128'd0);
        chk("sigout_d129", 128'(sig_out), 128'd0);
        chk("sb_drained", 128'(sb.size()), 128'd0);
    endtask

    initial begin
        rst     = 1'b1;
        launch  = 1'b0;
        dump    = 1'b0;
        aes_out = '0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            launch  = 1'($urandom);
            dump    = 1'($urandom);
            aes_out = {$urandom, $urandom, $urandom, $urandom};
            tick();
            chk("rst_sig_out", 128'(sig_out), 128'd0);
            chk("rst_valid", 128'(sig_valid), 128'd0);
            chk("rst_busy", 128'(busy), 128'd0);
            chk("rst_cnt", 128'(sample_cnt), 128'd0);
            chk("rst_ovr", 128'(overrun), 128'd0);
        end
        rst     = 1'b0;
        launch  = 1'b0;
        dump    = 1'b0;
        aes_out = {4{32'hA5A5_5A5A}};
        repeat (LAT + 3) tick();
        chk("rst_launch_no_fold", 128'(sample_cnt), 128'd0);
        aes_out = '0;

        // Empty readout
        do_dump();

        // Single fold of 1
        bd[0] = 128'h1;
        burst(1);
        chk("single_cnt", 128'(sample_cnt), 128'd1);
        chk("single_sig_model", exp_misr, 128'h1);
        do_dump();

        // Feedback tap
        bd[0] = {1'b1, 127'b0};
        bd[1] = 128'h0;
        burst(2);
        chk("fb_cnt", 128'(sample_cnt), 128'd2);
        chk("fb_sig_model", exp_misr, 128'h87);
        do_dump();

        // Consecutive random launches
        for (int i = 0; i < 4; i++) bd[i] = {$urandom, $urandom, $urandom, $urandom};
        burst(4);
        do_dump();

        // Overrun: vld arrives 10 cycles into readout
        bd[0] = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
        burst(1);
        launch = 1'b1;
        tick();
        launch  = 1'b0;
        aes_out = {4{32'hDEAD_BEEF}};
        repeat (10) tick();
        do_dump();
        chk("ovr_set", 128'(overrun), 128'd1);
        chk("ovr_cnt", 128'(sample_cnt), 128'd0);
        aes_out = '0;
        do_dump();
        chk("ovr_cleared", 128'(overrun), 128'd0);
        chk("ovr_cnt2", 128'(sample_cnt), 128'd0);

        // Reset mid-readout with a launch in flight
        bd[0] = 128'h5;
        burst(1);
        start_dump();
        repeat (40) tick();
        launch = 1'b1;
        tick();
        launch = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_valid", 128'(sig_valid), 128'd0);
        chk("mid_rst_sig_out", 128'(sig_out), 128'd0);
        sb.delete();
        aes_out = {4{32'h0BAD_F00D}};
        repeat (LAT + 5) tick();
        aes_out = '0;
        chk("mid_rst_cnt", 128'(sample_cnt), 128'd0);
        chk("mid_rst_ovr", 128'(overrun), 128'd0);
        do_dump();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_sig_collector.md
# aes_sig_collector

Downstream consumer of the `aes_128` core output in the AES test harness. It tracks which cycles carry a fresh ciphertext by delaying the input-launch strobe through the core's pipeline latency. It folds each valid 128-bit result into a MISR signature. On request it serializes the signature MSB-first on a 1-bit pin, replacing the single XOR-reduced output bit with a full, pin-efficient result stream.

## Interface
Parameters:
- `LATENCY`, 21: cycles from a `launch` cycle to the cycle in which `aes_out` holds the corresponding result; legal range 1..64.
- `CNT_W`, 16: width of `sample_cnt`.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `launch` in 1: the core's state/key input registers take a new value this cycle.
- `aes_out` in 128: core ciphertext output.
- `dump` in 1: request signature readout; single-cycle pulse or level.
- `sig_out` out 1: serial signature bit, MSB first.
- `sig_valid` out 1: `sig_out` is meaningful this cycle.
- `busy` out 1: readout in progress.
- `sample_cnt` out CNT_W: results folded since last readout; saturates at all-ones.
- `overrun` out 1: sticky flag; a result arrived during readout and was dropped.

## Operation
- **Delay line:** `LATENCY`-deep shift register of `launch`. Its output `vld` marks the cycle whose `aes_out` is a valid result.
- **MISR:** 128-bit register `misr`. On `vld` in state ACCUM: `misr <= {misr[126:0],1'b0} ^ (misr[127] ? MISR_POLY : 0) ^ aes_out`, with `MISR_POLY = 128'h87` (x^128+x^7+x^2+x+1). Otherwise `misr` holds.
- **Sample counter:** `sample_cnt` increments on each fold and saturates at `2^CNT_W-1`.
- **FSM states:** ACCUM (reset state) and SHIFT.
- **ACCUM → SHIFT on `dump`:**
  - Load `shreg` with the next-state value of `misr`, so a fold in the same cycle is included.
  - Clear bit counter `bitcnt` (7 bits).
  - Clear `misr`, `sample_cnt` and `overrun`.
- **In SHIFT:**
  - `shreg` shifts left one bit per cycle.
  - `bitcnt` increments each cycle.
  - After the 128th bit, return to ACCUM.
  - `dump` is ignored.
  - A `vld` sets `overrun`. The result is not folded and not counted.
- **Boundary cases:**
  - `launch` in consecutive cycles: every one is tracked independently, no loss.
  - `rst` at any point, including mid-SHIFT: next cycle state=ACCUM, delay line, `misr`, `shreg`, `bitcnt`, `sample_cnt` and `overrun` all cleared. Launches in flight are discarded.

## Timing
- Reset values: `sig_out=0`, `sig_valid=0`, `busy=0`, `sample_cnt=0`, `overrun=0`.
- `launch` high in cycle t → `aes_out` sampled and folded at the edge ending cycle t+LATENCY. `sample_cnt` shows the new value in cycle t+LATENCY+1.
- `dump` seen at edge ending cycle d → cycles d+1..d+128:
  - `busy=1` and `sig_valid=1`.
  - `sig_out` carries signature bits 127 down to 0, all registered outputs.
- Cycle d+129: `busy=0`, `sig_valid=0`, `sig_out=0`. A new `dump` is accepted from cycle d+129 onward.
- `overrun` rises the cycle after the dropped `vld` and holds until the next accepted `dump` or `rst`.

## Structure
- **Package `aes_sig_pkg`:**
  - `SIG_W=128`
  - `MISR_POLY=128'h87`
  - FSM state type {ACCUM, SHIFT}
  - `SIG_BITS_W=7`
- **Sub-module `launch_delay`:** parameterized `LATENCY`-deep 1-bit shift register with synchronous clear. Reused by any future stage aligned to the core pipeline.
- **Top of block:** MISR, counter, FSM and serializer.

## Test plan
- **Reset state:** hold `rst` 3 cycles with random inputs → all outputs 0. `launch` pulses issued during reset never fold.
- **Empty readout:** `dump` with no prior launches → `sig_valid` high exactly 128 cycles, all `sig_out=0`, `busy` low at d+129.
- **Single fold:** one `launch`, `aes_out=128'h1` at cycle t+21 → `sample_cnt=1`. `dump` yields 127 zeros then a final 1.
- **Feedback tap:** two launches one cycle apart, results `128'h8000…0` then `128'h0` → signature `128'h87`, `sample_cnt=2`.
- **Overrun:** `dump`, then a `vld` 10 cycles into SHIFT → `overrun=1`, serialized bits unchanged. Next `dump` clears `overrun`, `sample_cnt` reads 0.
- **Reset mid-readout:** `rst` after bit 50 of SHIFT → next cycle `busy=0`, `sig_valid=0`. A fresh `dump` then outputs 128 zeros.
